// File: rtl/trig_delay_gen.sv
// Delayed trigger pulse generator: detects a rising edge on trig_in and produces a pulse of
// programmable delay and width, followed by a holdoff window, with accept/miss statistics.
module trig_delay_gen #(
    parameter int DLY_W = 32,
    parameter int WID_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             trig_in,
    input  logic [DLY_W-1:0] delay_cnt,
    input  logic [WID_W-1:0] width_cnt,
    input  logic [DLY_W-1:0] holdoff_cnt,
    input  logic             clear_counts,
    output logic             pulse_out,
    output logic             busy,
    output logic [31:0]      trig_count,
    output logic [15:0]      missed_count
);

    localparam int CNT_W = (DLY_W > WID_W) ? DLY_W : WID_W;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_PULSE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    state_e           state_q, state_d, nom_state_s;
    logic [CNT_W-1:0] cnt_q, cnt_d, nom_cnt_s;
    logic [WID_W-1:0] wid_q, wid_d;
    logic [DLY_W-1:0] hold_q, hold_d;
    logic [31:0]      trig_cnt_q, trig_cnt_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             trig_hist_q;
    logic             edge_s, accept_s;
    logic [CNT_W-1:0] wid_ext_s, hold_ext_s, dly_in_s, wid_in_s, hold_in_s;

    assign wid_ext_s  = CNT_W'(wid_q);
    assign hold_ext_s = CNT_W'(hold_q);
    assign dly_in_s   = CNT_W'(delay_cnt);
    assign wid_in_s   = CNT_W'(width_cnt);
    assign hold_in_s  = CNT_W'(holdoff_cnt);
    assign edge_s     = trig_in & ~trig_hist_q;

    // Next state the operation in progress would take with no new trigger.
    always_comb begin
        nom_state_s = state_q;
        nom_cnt_s   = cnt_q - CNT_ONE;
        case (state_q)
            ST_IDLE: begin
                nom_state_s = ST_IDLE;
                nom_cnt_s   = CNT_ZERO;
            end
            ST_DELAY: begin
                if (cnt_q != CNT_ZERO) begin
                    nom_state_s = ST_DELAY;
                end else if (wid_q != {WID_W{1'b0}}) begin
                    nom_state_s = ST_PULSE;
                    nom_cnt_s   = wid_ext_s - CNT_ONE;
                end else if (hold_q != {DLY_W{1'b0}}) begin
                    nom_state_s = ST_HOLDOFF;
                    nom_cnt_s   = hold_ext_s - CNT_ONE;
                end else begin
                    nom_state_s = ST_IDLE;
                    nom_cnt_s   = CNT_ZERO;
                end
            end
            ST_PULSE: begin
                if (cnt_q != CNT_ZERO) begin
                    nom_state_s = ST_PULSE;
                end else if (hold_q != {DLY_W{1'b0}}) begin
                    nom_state_s = ST_HOLDOFF;
                    nom_cnt_s   = hold_ext_s - CNT_ONE;
                end else begin
                    nom_state_s = ST_IDLE;
                    nom_cnt_s   = CNT_ZERO;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q != CNT_ZERO) begin
                    nom_state_s = ST_HOLDOFF;
                end else begin
                    nom_state_s = ST_IDLE;
                    nom_cnt_s   = CNT_ZERO;
                end
            end
            default: begin
                nom_state_s = ST_IDLE;
                nom_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Acceptance, parameter latching, statistics and registered output values.
    always_comb begin
        state_d    = nom_state_s;
        cnt_d      = nom_cnt_s;
        wid_d      = wid_q;
        hold_d     = hold_q;
        trig_cnt_d = trig_cnt_q;
        miss_cnt_d = miss_cnt_q;
        // An edge landing on the cycle the FSM drops back to IDLE is still taken.
        accept_s   = edge_s && (nom_state_s == ST_IDLE);
        if (accept_s) begin
            wid_d      = width_cnt;
            hold_d     = holdoff_cnt;
            trig_cnt_d = trig_cnt_q + 32'd1;
            if (delay_cnt != {DLY_W{1'b0}}) begin
                state_d = ST_DELAY;
                cnt_d   = dly_in_s - CNT_ONE;
            end else if (width_cnt != {WID_W{1'b0}}) begin
                state_d = ST_PULSE;
                cnt_d   = wid_in_s - CNT_ONE;
            end else if (holdoff_cnt != {DLY_W{1'b0}}) begin
                state_d = ST_HOLDOFF;
                cnt_d   = hold_in_s - CNT_ONE;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        end else if (edge_s && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
        if (clear_counts) begin
            trig_cnt_d = 32'd0;
            miss_cnt_d = 16'd0;
        end else begin
            trig_cnt_d = trig_cnt_d;
        end
        pulse_d = (state_d == ST_PULSE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Trigger history follows trig_in every clock, independent of clk_enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_hist_q <= 1'b0;
        end else begin
            trig_hist_q <= trig_in;
        end
    end

    // FSM, counters and outputs; frozen while clk_enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            wid_q      <= {WID_W{1'b0}};
            hold_q     <= {DLY_W{1'b0}};
            trig_cnt_q <= 32'd0;
            miss_cnt_q <= 16'd0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else if (clk_enable) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wid_q      <= wid_d;
            hold_q     <= hold_d;
            trig_cnt_q <= trig_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
        end
    end

    assign pulse_out    = pulse_q;
    assign busy         = busy_q;
    assign trig_count   = trig_cnt_q;
    assign missed_count = miss_cnt_q;

endmodule

// File: tb/tb_trig_delay_gen.sv
// Scoreboard bench for trig_delay_gen: a timeline model predicts outputs per clock,
// expected words are queued at each edge and compared against the DUT just after it.
module tb_trig_delay_gen;

    logic        clk = 1'b0;
    logic        reset, clk_enable, trig_in, clear_counts;
    logic [31:0] delay_cnt, holdoff_cnt;
    logic [15:0] width_cnt;
    logic        pulse_out, busy;
    logic [31:0] trig_count;
    logic [15:0] missed_count;

    int total_n = 0;
    int bad_n   = 0;
    int cyc_n   = 0;
    int first_pulse_n, pulse_hi_n, edge_cyc_n;

    // model state
    bit          m_hist, m_act;
    longint      m_t, m_tot, m_d, m_w;
    logic [31:0] m_tc;
    logic [15:0] m_mc;
    logic [49:0] exp_q[$];

    always #5 clk = ~clk;

    trig_delay_gen #(.DLY_W(32), .WID_W(16)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .trig_in(trig_in),
        .delay_cnt(delay_cnt), .width_cnt(width_cnt), .holdoff_cnt(holdoff_cnt),
        .clear_counts(clear_counts), .pulse_out(pulse_out), .busy(busy),
        .trig_count(trig_count), .missed_count(missed_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        if (obs !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // Timeline model: t counts enabled cycles since acceptance, pulse spans [D, D+W).
    function automatic void model_step();
        bit e;
        e = trig_in && !m_hist;
        if (reset) begin
            m_hist = 1'b0; m_act = 1'b0; m_t = 0; m_tc = 32'd0; m_mc = 16'd0;
        end else begin
            m_hist = trig_in;
            if (clk_enable) begin
                if (m_act) begin
                    m_t++;
                    if (m_t >= m_tot) m_act = 1'b0;
                end
                if (e) begin
                    if (!m_act) begin
                        m_tc  = m_tc + 32'd1;
                        m_d   = longint'(delay_cnt);
                        m_w   = longint'(width_cnt);
                        m_tot = m_d + m_w + longint'(holdoff_cnt);
                        if (m_tot > 0) begin
                            m_act = 1'b1;
                            m_t   = 0;
                        end
                    end else if (m_mc != 16'hFFFF) begin
                        m_mc = m_mc + 16'd1;
                    end
                end
                if (clear_counts) begin
                    m_tc = 32'd0;
                    m_mc = 16'd0;
                end
            end
        end
    endfunction

    task automatic tick(input string tag);
        logic [49:0] e;
        bit          p;
        @(posedge clk);
        model_step();
        p = m_act && (m_t >= m_d) && (m_t < m_d + m_w);
        exp_q.push_back({p, m_act, m_tc, m_mc});
        #1;
        cyc_n++;
        e = exp_q.pop_front();
        chk(tag, 64'({pulse_out, busy, trig_count, missed_count}), 64'(e));
        if (pulse_out) begin
            pulse_hi_n++;
            if (first_pulse_n < 0) first_pulse_n = cyc_n;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; trig_in = 1'b0; clear_counts = 1'b0; clk_enable = 1'b1;
        tick("rst"); tick("rst");
        reset = 1'b0;
        first_pulse_n = -1; pulse_hi_n = 0;
    endtask

    task automatic set_dwh(input int d, input int w, input int h);
        delay_cnt = 32'(d); width_cnt = 16'(w); holdoff_cnt = 32'(h);
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; trig_in = 1'b0; clear_counts = 1'b0;
        set_dwh(0, 0, 0);
        do_reset();
        chk("reset_state", 64'({pulse_out, busy, trig_count, missed_count}), 64'd0);

        // single delayed pulse
        set_dwh(5, 3, 0);
        trig_in = 1'b1; tick("t030"); edge_cyc_n = cyc_n; trig_in = 1'b0;
        for (int i = 0; i < 12; i++) tick("t030");
        chk("t030_start", 64'(first_pulse_n - edge_cyc_n), 64'd5);
        chk("t030_width", 64'(pulse_hi_n), 64'd3);
        chk("t030_tc", 64'(trig_count), 64'd1);

        // back-to-back minimum spacing
        do_reset(); set_dwh(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            trig_in = 1'b1; tick("t031"); trig_in = 1'b0; tick("t031");
        end
        chk("t031_tc", 64'(trig_count), 64'd3);
        chk("t031_mc", 64'(missed_count), 64'd0);
        chk("t031_width", 64'(pulse_hi_n), 64'd3);

        // holdoff rejects, exit cycle accepts
        do_reset(); set_dwh(2, 2, 10);
        for (int c = 0; c < 20; c++) begin
            trig_in = (c == 0 || c == 8 || c == 14);
            if (c == 1) set_dwh(7, 7, 7);
            tick("t032");
            if (c == 13) chk("t032_pulses", 64'(pulse_hi_n), 64'd2);
        end
        trig_in = 1'b0;
        chk("t032_mc", 64'(missed_count), 64'd1);
        chk("t032_tc", 64'(trig_count), 64'd2);

        // enable stall during DELAY
        do_reset(); set_dwh(4, 4, 0);
        trig_in = 1'b1; tick("t033"); edge_cyc_n = cyc_n; trig_in = 1'b0;
        tick("t033");
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) tick("t033");
        clk_enable = 1'b1;
        for (int i = 0; i < 12; i++) tick("t033");
        chk("t033_start", 64'(first_pulse_n - edge_cyc_n), 64'd7);
        chk("t033_width", 64'(pulse_hi_n), 64'd4);

        // reset mid-pulse
        do_reset(); set_dwh(0, 8, 0);
        trig_in = 1'b1; tick("t034"); trig_in = 1'b0; tick("t034");
        reset = 1'b1; tick("t034");
        chk("t034_abort", 64'({pulse_out, busy, trig_count}), 64'd0);
        reset = 1'b0; pulse_hi_n = 0;
        for (int i = 0; i < 10; i++) tick("t034");
        chk("t034_residual", 64'(pulse_hi_n), 64'd0);

        // trig_in held high through reset release
        reset = 1'b1; trig_in = 1'b1; set_dwh(1, 1, 0);
        tick("t029"); tick("t029");
        reset = 1'b0; tick("t029");
        chk("t029_tc", 64'(trig_count), 64'd1);
        trig_in = 1'b0;
        for (int i = 0; i < 4; i++) tick("t029");

        // missed_count saturation, then clear with an edge
        do_reset(); set_dwh(200000, 1, 0);
        trig_in = 1'b1; tick("t035"); trig_in = 1'b0; tick("t035");
        for (int i = 0; i < 65540; i++) begin
            trig_in = 1'b1; tick("t035"); trig_in = 1'b0; tick("t035");
        end
        chk("t035_sat", 64'(missed_count), 64'hFFFF);
        trig_in = 1'b1; clear_counts = 1'b1; tick("t035");
        trig_in = 1'b0; clear_counts = 1'b0;
        chk("t035_clr", 64'({trig_count, missed_count}), 64'd0);

        // randomised traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            trig_in      = 1'($urandom_range(0, 1));
            clk_enable   = ($urandom_range(0, 9) != 0);
            clear_counts = ($urandom_range(0, 39) == 0);
            reset        = ($urandom_range(0, 149) == 0);
            set_dwh($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
